// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2-D pooling engine.
//   pool_mode_t  : reduction mode (max / average)
//   pool_state_t : engine sequencer states
//   log2_ceil    : constant function, smallest r with 2**r >= value
package pool_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        DRAIN  = 3'd2,
        WRITE  = 3'd3,
        FINISH = 3'd4
    } pool_state_t;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pool2d_engine_if.sv
// Memory-side bus of the pooling engine: a read port into the source
// feature-map BRAM and a write port into the destination BRAM.
//   in_addr/in_en  : source read request (data returns on in_q one cycle later)
//   in_q           : source read data
//   out_addr/out_en/out_we/out_d : destination write port
// modport master : engine side, modport slave : memory side.
interface pool2d_engine_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IN_AW      = 10,
    parameter int OUT_AW     = 8
);
    logic        [IN_AW-1:0]      in_addr;
    logic                         in_en;
    logic signed [DATA_WIDTH-1:0] in_q;
    logic        [OUT_AW-1:0]     out_addr;
    logic                         out_en;
    logic                         out_we;
    logic signed [DATA_WIDTH-1:0] out_d;

    modport master (
        output in_addr, in_en, out_addr, out_en, out_we, out_d,
        input  in_q
    );

    modport slave (
        input  in_addr, in_en, out_addr, out_en, out_we, out_d,
        output in_q
    );
endinterface

// File: rtl/pool_reduce.sv
// Window reducer: folds one signed sample per cycle into a running max or
// sum. A sample flagged 'clear' restarts the window (the max starts from the
// first sample, never from zero).
//   valid/clear/sample : incoming sample, clear marks the first of a window
//   mode               : POOL_MAX or POOL_AVG
//   result             : reduction including the sample presented this cycle
module pool_reduce
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SAMPLES    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid,
    input  logic                         clear,
    input  pool_mode_t                   mode,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic signed [DATA_WIDTH-1:0] result
);
    localparam int SHIFT = log2_ceil(SAMPLES);
    localparam int ACC_W = DATA_WIDTH + SHIFT;

    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] acc_next_s;
    logic signed [ACC_W-1:0] sample_ext_s;
    logic signed [ACC_W-1:0] shifted_s;

    // Next accumulator value and the result it implies; the result is taken
    // from the next value so the final sample is visible without an extra cycle.
    always_comb begin
        sample_ext_s = ACC_W'(sample);
        acc_next_s   = acc_r;
        if (valid) begin
            if (clear) begin
                acc_next_s = sample_ext_s;
            end else if (mode == POOL_AVG) begin
                acc_next_s = acc_r + sample_ext_s;
            end else if (sample_ext_s > acc_r) begin
                acc_next_s = sample_ext_s;
            end else begin
                acc_next_s = acc_r;
            end
        end else begin
            acc_next_s = acc_r;
        end
        // Arithmetic shift floors toward -inf for negative sums.
        shifted_s = acc_next_s >>> SHIFT;
        if (mode == POOL_AVG) begin
            result = shifted_s[DATA_WIDTH-1:0];
        end else begin
            result = acc_next_s[DATA_WIDTH-1:0];
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= '0;
        end else begin
            acc_r <= acc_next_s;
        end
    end

endmodule

// File: rtl/pool2d_engine.sv
// 2-D max/average pooling engine over a CHW feature map held in BRAM.
// Each output window takes POOL*POOL read cycles, one drain cycle (last read
// data returns) and one write cycle; windows run back to back.
//   clk, reset  : clock, synchronous active-high reset
//   start, mode : run request (IDLE only) and reduction mode (0 max, 1 avg)
//   busy, done  : run in progress / one-cycle completion pulse
//   mem         : source read and destination write ports
// AVG_ENABLE = 0 builds a max-only engine (mode is then ignored); average
// requires a power-of-two window, so POOL = 3 needs AVG_ENABLE = 0.
module pool2d_engine
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IN_H       = 28,
    parameter int IN_W       = 28,
    parameter int POOL       = 2,
    parameter int STRIDE     = 2,
    parameter bit AVG_ENABLE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mode,
    output logic            busy,
    output logic            done,
    pool2d_engine_if.master mem
);
    localparam int OUT_H  = (IN_H - POOL) / STRIDE + 1;
    localparam int OUT_W  = (IN_W - POOL) / STRIDE + 1;
    localparam int KK     = POOL * POOL;
    localparam int IN_AW  = $clog2(CHANNELS * IN_H * IN_W);
    localparam int OUT_AW = $clog2(CHANNELS * OUT_H * OUT_W);
    localparam int KW     = $clog2(KK + 1);
    localparam int JW     = $clog2(POOL + 1);
    localparam int XW     = $clog2(OUT_W + 1);
    localparam int YW     = $clog2(OUT_H + 1);
    localparam int CW     = $clog2(CHANNELS + 1);

    // Pointer steps: next row inside a window, next window, next window row,
    // next channel. Constant products only, no runtime multipliers.
    localparam logic [IN_AW-1:0] ROW_WRAP = IN_AW'(IN_W - POOL + 1);
    localparam logic [IN_AW-1:0] WIN_STEP = IN_AW'(STRIDE);
    localparam logic [IN_AW-1:0] ROW_STEP = IN_AW'(STRIDE * IN_W);
    localparam logic [IN_AW-1:0] CH_STEP  = IN_AW'(IN_H * IN_W);

    if (POOL < 2 || POOL > 4) begin : g_bad_pool
        $error("pool2d_engine: POOL must be 2..4");
    end
    if (POOL > IN_H || POOL > IN_W) begin : g_bad_size
        $error("pool2d_engine: POOL exceeds input size");
    end
    if (STRIDE < 1 || STRIDE > POOL) begin : g_bad_stride
        $error("pool2d_engine: STRIDE must be 1..POOL");
    end
    if (AVG_ENABLE && POOL == 3) begin : g_bad_avg
        $error("pool2d_engine: average mode needs a power-of-two window");
    end

    pool_state_t                  state_r, state_s;
    pool_mode_t                   mode_r, mode_s;
    logic        [KW-1:0]         k_r, k_s;
    logic        [JW-1:0]         j_r, j_s;
    logic        [IN_AW-1:0]      in_addr_r, in_addr_s;
    logic        [IN_AW-1:0]      win_base_r, win_base_s;
    logic        [IN_AW-1:0]      row_base_r, row_base_s;
    logic        [IN_AW-1:0]      ch_base_r, ch_base_s;
    logic        [IN_AW-1:0]      next_base_s;
    logic        [XW-1:0]         ox_r, ox_s;
    logic        [YW-1:0]         oy_r, oy_s;
    logic        [CW-1:0]         ch_r, ch_s;
    logic        [OUT_AW-1:0]     out_addr_r, out_addr_s;
    logic signed [DATA_WIDTH-1:0] out_d_r, out_d_s;
    logic                         in_en_r, in_en_s;
    logic                         out_we_r, out_we_s;
    logic                         busy_r, busy_s;
    logic                         done_r, done_s;
    logic                         smp_valid_r, smp_first_r;
    logic                         last_win_s;
    logic signed [DATA_WIDTH-1:0] red_result_s;

    pool_reduce #(
        .DATA_WIDTH (DATA_WIDTH),
        .SAMPLES    (KK)
    ) u_reduce (
        .clk    (clk),
        .reset  (reset),
        .valid  (smp_valid_r),
        .clear  (smp_first_r),
        .mode   (mode_r),
        .sample (mem.in_q),
        .result (red_result_s)
    );

    // Next-state, address walk and next values of the registered outputs.
    always_comb begin
        state_s     = state_r;
        mode_s      = mode_r;
        k_s         = k_r;
        j_s         = j_r;
        in_addr_s   = in_addr_r;
        win_base_s  = win_base_r;
        row_base_s  = row_base_r;
        ch_base_s   = ch_base_r;
        next_base_s = win_base_r;
        ox_s        = ox_r;
        oy_s        = oy_r;
        ch_s        = ch_r;
        out_addr_s  = out_addr_r;
        out_d_s     = out_d_r;
        in_en_s     = 1'b0;
        out_we_s    = 1'b0;
        busy_s      = busy_r;
        done_s      = 1'b0;
        last_win_s  = (ox_r == XW'(OUT_W - 1)) && (oy_r == YW'(OUT_H - 1)) &&
                      (ch_r == CW'(CHANNELS - 1));
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s    = READ;
                    mode_s     = (AVG_ENABLE && mode) ? POOL_AVG : POOL_MAX;
                    busy_s     = 1'b1;
                    k_s        = '0;
                    j_s        = '0;
                    in_addr_s  = '0;
                    win_base_s = '0;
                    row_base_s = '0;
                    ch_base_s  = '0;
                    ox_s       = '0;
                    oy_s       = '0;
                    ch_s       = '0;
                    out_addr_s = '0;
                    in_en_s    = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            READ: begin
                if (k_r == KW'(KK - 1)) begin
                    state_s = DRAIN;
                end else begin
                    in_en_s = 1'b1;
                    k_s     = k_r + KW'(1);
                    if (j_r == JW'(POOL - 1)) begin
                        j_s       = '0;
                        in_addr_s = in_addr_r + ROW_WRAP;
                    end else begin
                        j_s       = j_r + JW'(1);
                        in_addr_s = in_addr_r + IN_AW'(1);
                    end
                end
            end
            DRAIN: begin
                state_s  = WRITE;
                out_we_s = 1'b1;
                out_d_s  = red_result_s;
            end
            WRITE: begin
                if (last_win_s) begin
                    state_s = FINISH;
                    done_s  = 1'b1;
                end else begin
                    if (ox_r != XW'(OUT_W - 1)) begin
                        ox_s        = ox_r + XW'(1);
                        next_base_s = win_base_r + WIN_STEP;
                    end else if (oy_r != YW'(OUT_H - 1)) begin
                        ox_s        = '0;
                        oy_s        = oy_r + YW'(1);
                        next_base_s = row_base_r + ROW_STEP;
                        row_base_s  = next_base_s;
                    end else begin
                        ox_s        = '0;
                        oy_s        = '0;
                        ch_s        = ch_r + CW'(1);
                        next_base_s = ch_base_r + CH_STEP;
                        ch_base_s   = next_base_s;
                        row_base_s  = next_base_s;
                    end
                    state_s    = READ;
                    win_base_s = next_base_s;
                    in_addr_s  = next_base_s;
                    k_s        = '0;
                    j_s        = '0;
                    in_en_s    = 1'b1;
                    out_addr_s = out_addr_r + OUT_AW'(1);
                end
            end
            FINISH: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, walk pointers, registered outputs and the read-return pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            mode_r      <= POOL_MAX;
            k_r         <= '0;
            j_r         <= '0;
            in_addr_r   <= '0;
            win_base_r  <= '0;
            row_base_r  <= '0;
            ch_base_r   <= '0;
            ox_r        <= '0;
            oy_r        <= '0;
            ch_r        <= '0;
            out_addr_r  <= '0;
            out_d_r     <= '0;
            in_en_r     <= 1'b0;
            out_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            smp_valid_r <= 1'b0;
            smp_first_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            mode_r      <= mode_s;
            k_r         <= k_s;
            j_r         <= j_s;
            in_addr_r   <= in_addr_s;
            win_base_r  <= win_base_s;
            row_base_r  <= row_base_s;
            ch_base_r   <= ch_base_s;
            ox_r        <= ox_s;
            oy_r        <= oy_s;
            ch_r        <= ch_s;
            out_addr_r  <= out_addr_s;
            out_d_r     <= out_d_s;
            in_en_r     <= in_en_s;
            out_we_r    <= out_we_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            // Read data arrives one cycle after its issue; issue 0 opens a window.
            smp_valid_r <= in_en_r;
            smp_first_r <= in_en_r && (k_r == KW'(0));
        end
    end

    assign mem.in_addr  = in_addr_r;
    assign mem.in_en    = in_en_r;
    assign mem.out_addr = out_addr_r;
    assign mem.out_en   = out_we_r;
    assign mem.out_we   = out_we_r;
    assign mem.out_d    = out_d_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: doc/pool2d_engine.md
POOL2D_ENGINE -- requirements
Module: pool2d_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed sample width.
REQ-002 Parameter CHANNELS, default 8: feature-map channel count.
REQ-003 Parameter IN_H, default 28: input rows.
REQ-004 Parameter IN_W, default 28: input columns.
REQ-005 Parameter POOL, default 2: square window edge K, 2..4.
REQ-006 Parameter STRIDE, default 2: window step, 1..POOL.
REQ-007 Derived OUT_H = (IN_H-POOL)/STRIDE+1, OUT_W = (IN_W-POOL)/STRIDE+1; IN_AW = clog2(CHANNELS*IN_H*IN_W); OUT_AW = clog2(CHANNELS*OUT_H*OUT_W).
REQ-008 clk  in  1  clock; reset, synchronous, active-high; clock clk.
REQ-009 reset  in  1  synchronous active-high reset.
REQ-010 start  in  1  single-cycle run request, honoured only in IDLE.
REQ-011 mode  in  1  0 = max, 1 = average; sampled on accepted start.
REQ-012 in_addr  out  IN_AW  source BRAM address, CHW layout.
REQ-013 in_en  out  1  source read enable.
REQ-014 in_q  in  DATA_WIDTH signed  source read data, valid 1 cycle after in_en.
REQ-015 out_addr  out  OUT_AW  destination address, CHW layout.
REQ-016 out_en, out_we  out  1 each  destination enable/write strobe, asserted together.
REQ-017 out_d  out  DATA_WIDTH signed  pooled value.
REQ-018 busy  out  1  high from cycle after accepted start until done cycle inclusive.
REQ-019 done  out  1  one-cycle pulse after last write.

Function
REQ-020 States IDLE, READ, DRAIN, WRITE, FINISH; IDLE->READ on start; READ->DRAIN after K*K issues; DRAIN->WRITE; WRITE->READ (more windows) or FINISH; FINISH->IDLE.
REQ-021 READ issues one address per cycle, row-major within window (window base + i*IN_W + j), in_en high each READ cycle; in_q for issue n captured in the following cycle.
REQ-022 Window cycle count SHALL be exactly K*K+2 (K*K READ, 1 DRAIN, 1 WRITE); no idle gaps between windows.
REQ-023 Window order: column fastest, then row, then channel; window base advances by a running linear pointer (+STRIDE, row step, channel step), no multipliers.
REQ-024 Max mode: reducer initialised from first sample (not zero), signed compare.
REQ-025 Average mode: accumulator DATA_WIDTH+clog2(K*K) bits signed, result = sum >>> log2(K*K) (floor toward -inf), truncated to DATA_WIDTH; average with K=3 SHALL be rejected at elaboration.
REQ-026 out_addr increments by 1 per window from 0; final address CHANNELS*OUT_H*OUT_W-1.
REQ-027 start in any state other than IDLE SHALL be ignored; mode changes mid-run ignored.
REQ-028 done asserted in FINISH cycle only; start coincident with done ignored; start in following IDLE cycle accepted.
REQ-029 Total start-to-done latency = CHANNELS*OUT_H*OUT_W*(K*K+2)+2 cycles.

Reset
REQ-030 reset SHALL dominate start and return FSM to IDLE from any state, including mid-window.
REQ-031 Reset values: in_addr, out_addr, out_d, accumulators, pointers = 0; in_en, out_en, out_we, busy, done = 0.
REQ-032 No destination write SHALL occur in the cycle after reset asserts.

Structure
REQ-033 Package pool_pkg holds pool_mode_t enum (POOL_MAX, POOL_AVG), pool_state_t, and log2 helper constant function.
REQ-034 One sub-module pool_reduce: accumulates one sample/cycle with clear, mode, and result outputs; FSM and address walk stay in pool2d_engine.
REQ-035 Elaboration assertions: POOL<=IN_H, POOL<=IN_W, 1<=STRIDE<=POOL.

Verification
REQ-036 CH=1, 4x4 input 0..15, K=2, S=2, max -> writes 5,7,13,15 at addr 0..3; done at cycle 26 after start.
REQ-037 Same input, average -> writes 2,4,10,12.
REQ-038 Window {-1,-2,-3,-4}, max -> -1; average -> -3.
REQ-039 CH=2, 4x4, K=3, S=1, max, ch1 = ch0+100 -> 8 writes, ch0 10,11,14,15, ch1 110,111,114,115.
REQ-040 reset asserted mid-READ of window 2 -> next cycle all outputs 0, state IDLE, fresh start reproduces REQ-036 results.
REQ-041 start pulsed repeatedly during busy -> exactly one done pulse, write count unchanged.
